// File: rtl/spi_master_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_master_arbiter_if
//   Bundles the requester-side handshake and the SPI pin-side signals of
//   spi_master_arbiter. Clock and reset are kept outside the interface.
//
//   master modport : the arbiter itself (drives gnt/done/rdata/busy and pins)
//   slave  modport : requesters plus SPI slave (drive req_* and miso)
//
//   req        requester i asserts and holds until gnt[i]
//   req_rd_wr  per requester: 1 = write, 0 = read
//   req_addr   packed, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  packed, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-hot, one-cycle grant pulse
//   done       one-hot, one-cycle pulse in the end-of-frame gap cycle
//   rdata      read data, valid with done of a read frame, held otherwise
//   busy       high from the grant cycle through the gap cycle
//   mosi/miso  serial data, MSB first
//   ssel       slave select, active low
//   rd_wr      frame direction, stable for the whole frame
// ----------------------------------------------------------------------------
interface spi_master_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_rd_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mosi;
    logic                      miso;
    logic                      ssel;
    logic                      rd_wr;

    modport master (
        input  req, req_rd_wr, req_addr, req_wdata, miso,
        output gnt, done, rdata, busy, mosi, ssel, rd_wr
    );

    modport slave (
        output req, req_rd_wr, req_addr, req_wdata, miso,
        input  gnt, done, rdata, busy, mosi, ssel, rd_wr
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// ----------------------------------------------------------------------------
// spi_master_arbiter
//   Shares one SPI master port between NUM_REQ requesters. A round-robin
//   arbiter picks a requester while idle; the FSM then runs one frame:
//   ADDR_W address bits, DATA_W data bits (write: shifted out, read: miso
//   shifted in), then a one-cycle gap in which done/rdata are presented.
//
//   sclk  : clock, everything changes and miso is sampled on its rising edge
//   rst   : synchronous, active-high reset
//   bus   : spi_master_arbiter_if.master (requester handshake + SPI pins)
// ----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic                  sclk,
    input  logic                  rst,
    spi_master_arbiter_if.master  bus
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_sh_q;
    logic [DATA_W-1:0]   data_sh_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q;
    logic                mosi_q;
    logic                ssel_q;
    logic                rd_wr_q;

    // Round-robin pick: first requester at or after ptr_q, wrapping.
    logic                found_d;
    logic [PTR_W-1:0]    win_d;
    logic [PTR_W-1:0]    ptr_d;
    logic [NUM_REQ-1:0]  win_onehot_d;
    logic [ADDR_W-1:0]   win_addr_d;
    logic [DATA_W-1:0]   win_wdata_d;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        found_d      = 1'b0;
        win_d        = ptr_q;
        win_onehot_d = '0;
        // Walk offsets from far to near so the nearest requester wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req[idx]) begin
                found_d = 1'b1;
                win_d   = PTR_W'(idx);
            end
        end
        win_onehot_d[win_d] = 1'b1;
        ptr_d       = (win_d == PTR_W'(NUM_REQ - 1)) ? '0 : win_d + PTR_W'(1);
        win_addr_d  = bus.req_addr[int'(win_d)*ADDR_W +: ADDR_W];
        win_wdata_d = bus.req_wdata[int'(win_d)*DATA_W +: DATA_W];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ssel_q    <= 1'b1;
            rd_wr_q   <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        // Grant cycle is also the first address bit cycle.
                        gnt_q     <= win_onehot_d;
                        owner_q   <= win_d;
                        ptr_q     <= ptr_d;
                        rd_wr_q   <= bus.req_rd_wr[win_d];
                        addr_sh_q <= win_addr_d << 1;
                        data_sh_q <= win_wdata_d;
                        mosi_q    <= win_addr_d[ADDR_W-1];
                        ssel_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        // Reads drive mosi low during the data phase.
                        mosi_q    <= rd_wr_q & data_sh_q[DATA_W-1];
                        data_sh_q <= {data_sh_q[DATA_W-2:0], 1'b0};
                        cnt_q     <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        mosi_q    <= addr_sh_q[ADDR_W-1];
                        addr_sh_q <= addr_sh_q << 1;
                        cnt_q     <= cnt_q + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    // One register serves both directions: write bits leave
                    // from the top while miso samples enter at the bottom.
                    data_sh_q <= {data_sh_q[DATA_W-2:0], bus.miso};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        ssel_q          <= 1'b1;
                        mosi_q          <= 1'b0;
                        done_q[owner_q] <= 1'b1;
                        if (!rd_wr_q) begin
                            rdata_q <= {data_sh_q[DATA_W-2:0], bus.miso};
                        end
                        state_q <= ST_GAP;
                    end else begin
                        mosi_q <= rd_wr_q & data_sh_q[DATA_W-1];
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.mosi  = mosi_q;
    assign bus.ssel  = ssel_q;
    assign bus.rd_wr = rd_wr_q;

endmodule
